reg_file_reader: RTL and testbench

Register-file read side for the single-issue core. It holds the 32 architectural registers and accepts write-back data from the write-back select mux. It serves paired source-operand reads (rs1/rs2) to decode with a one-cycle registered response. A per-register pending scoreboard stalls reads of registers whose multi-cycle producer (load, CSR) has issued but not yet written back. A same-cycle write-to-read bypass is included.

---
 rtl/reg_file_reader.sv | 171 +++++++++++++++++
 tb/tb_reg_file_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_reader.sv
// -----------------------------------------------------------------------------
// reg_file_reader
//
// Read side of the integer register file for the single-issue core.
// Holds x1..x(NREG-1) as flops (x0 is hard-wired to zero), accepts write-back
// data, and serves paired rs1/rs2 operand reads with a one-cycle registered
// response. A per-register pending scoreboard tracks multi-cycle producers
// (loads, CSR reads) that have issued but not yet written back, and stalls
// any read of such a register. A write landing in the same cycle as a read
// is bypassed straight into the response.
//
// Ports
//   CLK        core clock, all state changes on the rising edge
//   RST_N      synchronous active-low reset
//   WE/WA/WD   write-back enable, destination register, data
//   ISSUE_EN   a multi-cycle producer issued this cycle
//   ISSUE_RD   destination of that producer (marked pending)
//   REQ_VALID  decode requests an operand read
//   REQ_RS1/2  source register addresses
//   REQ_READY  request accepted when high together with REQ_VALID
//   RSP_VALID  one-cycle pulse, RS1_DATA/RS2_DATA valid
//   RS1_DATA   source 1 operand (holds between responses)
//   RS2_DATA   source 2 operand (holds between responses)
//   PENDING    scoreboard state, bit 0 always 0
// -----------------------------------------------------------------------------
module reg_file_reader #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WE,
    input  logic [AW-1:0]   WA,
    input  logic [XLEN-1:0] WD,
    input  logic            ISSUE_EN,
    input  logic [AW-1:0]   ISSUE_RD,
    input  logic            REQ_VALID,
    input  logic [AW-1:0]   REQ_RS1,
    input  logic [AW-1:0]   REQ_RS2,
    output logic            REQ_READY,
    output logic            RSP_VALID,
    output logic [XLEN-1:0] RS1_DATA,
    output logic [XLEN-1:0] RS2_DATA,
    output logic [NREG-1:0] PENDING
);

    // Architectural state
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Response registers
    logic            rsp_valid_q;
    logic            rsp_valid_d;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] rs2_data_d;

    // Decoded write / issue qualifiers (x0 targets are dropped)
    logic            wr_en;
    logic            iss_en;
    logic            hazard_rs1;
    logic            hazard_rs2;
    logic            req_ready;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // A pending source stalls unless the resolving write lands this very
    // cycle; in that case the bypass supplies the data, so the stall releases
    // with no dead cycle.
    function automatic logic is_hazard(
        input logic [AW-1:0]   rs,
        input logic [NREG-1:0] pend,
        input logic            we,
        input logic [AW-1:0]   wa
    );
        return (rs != '0) && pend[rs] && !(we && (wa == rs));
    endfunction

    always_comb begin
        wr_en  = WE && (WA != '0);
        iss_en = ISSUE_EN && (ISSUE_RD != '0);

        hazard_rs1 = is_hazard(REQ_RS1, pending_q, WE, WA);
        hazard_rs2 = is_hazard(REQ_RS2, pending_q, WE, WA);
        req_ready  = RST_N && !hazard_rs1 && !hazard_rs2;
        accept     = REQ_VALID && req_ready;
    end

    // Operand select: zero register, then same-cycle bypass, then array.
    always_comb begin
        rs1_val = regs_q[REQ_RS1];
        if (WE && (WA == REQ_RS1)) begin
            rs1_val = WD;
        end
        if (REQ_RS1 == '0) begin
            rs1_val = '0;
        end

        rs2_val = regs_q[REQ_RS2];
        if (WE && (WA == REQ_RS2)) begin
            rs2_val = WD;
        end
        if (REQ_RS2 == '0) begin
            rs2_val = '0;
        end
    end

    // Next-state for register array and scoreboard.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        pending_d = pending_q;

        if (wr_en) begin
            regs_d[WA]    = WD;
            pending_d[WA] = 1'b0;
        end
        // Applied after the write clear: a producer issued in the same cycle
        // as a write-back to the same register is newer and keeps it pending.
        if (iss_en) begin
            pending_d[ISSUE_RD] = 1'b1;
        end

        regs_d[0]    = '0;
        pending_d[0] = 1'b0;
    end

    // Response capture: data holds between accepts.
    always_comb begin
        rsp_valid_d = accept;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        if (accept) begin
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pending_q   <= '0;
            rsp_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    assign REQ_READY = req_ready;
    assign RSP_VALID = rsp_valid_q;
    assign RS1_DATA  = rs1_data_q;
    assign RS2_DATA  = rs2_data_q;
    assign PENDING   = pending_q;

endmodule

// File: tb/tb_reg_file_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_file_reader
//
// Directed scenarios plus a randomized run for reg_file_reader, checked
// against a behavioural model of the register file and scoreboard kept as
// plain arrays inside the bench.
// -----------------------------------------------------------------------------
module tb_reg_file_reader;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        req_valid;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        REQ_READY;
    logic        RSP_VALID;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic [31:0] PENDING;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit   [31:0] m_pend;
    bit          m_rv;
    logic [31:0] m_d1;
    logic [31:0] m_d2;

    reg_file_reader #(.XLEN(32), .NREG(32)) dut (
        .CLK      (CLK),
        .RST_N    (rst_n),
        .WE       (we),
        .WA       (wa),
        .WD       (wd),
        .ISSUE_EN (issue_en),
        .ISSUE_RD (issue_rd),
        .REQ_VALID(req_valid),
        .REQ_RS1  (req_rs1),
        .REQ_RS2  (req_rs2),
        .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID),
        .RS1_DATA (RS1_DATA),
        .RS2_DATA (RS2_DATA),
        .PENDING  (PENDING)
    );

    always #5 CLK = ~CLK;

    // ---------------- model ----------------
    function automatic bit m_stalled(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (!m_pend[rs]) return 1'b0;
        if (we && wa == rs) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return rst_n && !m_stalled(req_rs1) && !m_stalled(req_rs2);
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (we && wa == rs) return wd;
        return m_regs[rs];
    endfunction

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic set_in(input bit i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                          input bit i_iss, input logic [4:0] i_ird,
                          input bit i_vld, input logic [4:0] i_rs1, input logic [4:0] i_rs2);
        we = i_we; wa = i_wa; wd = i_wd;
        issue_en = i_iss; issue_rd = i_ird;
        req_valid = i_vld; req_rs1 = i_rs1; req_rs2 = i_rs2;
        #1;
    endtask

    // Advance the model by one clock with the current inputs, then the DUT.
    task automatic tick();
        bit acc;
        acc = req_valid && m_ready();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_pend = '0;
            m_rv = 1'b0;
            m_d1 = 32'd0;
            m_d2 = 32'd0;
        end else begin
            m_rv = acc;
            if (acc) begin
                m_d1 = m_operand(req_rs1);
                m_d2 = m_operand(req_rs2);
            end
            if (we && wa != 5'd0) begin
                m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (issue_en && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 5'd5, 5'd31);
            n_checks++;
            if (REQ_READY !== 1'b0) $display("FAIL reset_ready got %b exp 0", REQ_READY);
            else n_pass++;
            tick();
            n_checks++;
            if (RSP_VALID !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", RSP_VALID);
            else n_pass++;
            n_checks++;
            if (PENDING !== 32'd0) $display("FAIL reset_pending got %h exp 0", PENDING);
            else n_pass++;
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 1, 5'd5, 5'd31);
        n_checks++;
        if (REQ_READY !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", REQ_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'd0 || RS2_DATA !== 32'd0)
            $display("FAIL post_reset_read got v=%b %h %h exp v=1 0 0", RSP_VALID, RS1_DATA, RS2_DATA);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_write_read();
        set_in(1, 5'd5, 32'h12345678, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 5'd5, 5'd0);
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'h12345678 || RS2_DATA !== 32'd0)
            $display("FAIL write_read got v=%b %h %h exp v=1 12345678 0", RSP_VALID, RS1_DATA, RS2_DATA);
        else n_pass++;
        idle();
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b0 || RS1_DATA !== 32'h12345678)
            $display("FAIL data_hold got v=%b %h exp v=0 12345678", RSP_VALID, RS1_DATA);
        else n_pass++;
    endtask

    task automatic test_bypass();
        set_in(1, 5'd7, 32'hDEADBEEF, 0, 0, 1, 5'd7, 5'd7);
        n_checks++;
        if (REQ_READY !== 1'b1) $display("FAIL bypass_ready got %b exp 1", REQ_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'hDEADBEEF || RS2_DATA !== 32'hDEADBEEF)
            $display("FAIL bypass_data got v=%b %h %h exp v=1 deadbeef deadbeef", RSP_VALID, RS1_DATA, RS2_DATA);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_stall();
        set_in(0, 0, 0, 1, 5'd3, 0, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 5'd0, 5'd3);
            n_checks++;
            if (REQ_READY !== 1'b0 || PENDING[3] !== 1'b1)
                $display("FAIL stall_cycle%0d got ready=%b pend3=%b exp ready=0 pend3=1", c, REQ_READY, PENDING[3]);
            else n_pass++;
            tick();
            n_checks++;
            if (RSP_VALID !== 1'b0) $display("FAIL stall_rsp%0d got %b exp 0", c, RSP_VALID);
            else n_pass++;
        end
        set_in(1, 5'd3, 32'hA5A5A5A5, 0, 0, 1, 5'd0, 5'd3);
        n_checks++;
        if (REQ_READY !== 1'b1) $display("FAIL stall_release_ready got %b exp 1", REQ_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS2_DATA !== 32'hA5A5A5A5 || PENDING[3] !== 1'b0)
            $display("FAIL stall_release_rsp got v=%b rs2=%h pend3=%b exp v=1 a5a5a5a5 0", RSP_VALID, RS2_DATA, PENDING[3]);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_x0();
        set_in(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 5'd0);
        n_checks++;
        if (REQ_READY !== 1'b1) $display("FAIL x0_ready got %b exp 1", REQ_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (PENDING[0] !== 1'b0 || RSP_VALID !== 1'b1 || RS1_DATA !== 32'd0)
            $display("FAIL x0_read got pend0=%b v=%b rs1=%h exp 0 1 0", PENDING[0], RSP_VALID, RS1_DATA);
        else n_pass++;
        set_in(0, 0, 0, 0, 0, 1, 5'd0, 5'd0);
        tick();
        n_checks++;
        if (RS1_DATA !== 32'd0 || PENDING !== 32'd0)
            $display("FAIL x0_after got rs1=%h pend=%h exp 0 0", RS1_DATA, PENDING);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(1, 5'd10, 32'h0000AAAA, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 5'd11, 32'h0000BBBB, 0, 0, 1, 5'd10, 5'd11);
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'h0000AAAA || RS2_DATA !== 32'h0000BBBB)
            $display("FAIL b2b_first got v=%b %h %h exp v=1 0000aaaa 0000bbbb", RSP_VALID, RS1_DATA, RS2_DATA);
        else n_pass++;
        set_in(0, 0, 0, 0, 0, 1, 5'd11, 5'd10);
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'h0000BBBB || RS2_DATA !== 32'h0000AAAA)
            $display("FAIL b2b_second got v=%b %h %h exp v=1 0000bbbb 0000aaaa", RSP_VALID, RS1_DATA, RS2_DATA);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_write_issue_reset();
        set_in(0, 0, 0, 1, 5'd9, 0, 0, 0);
        tick();
        set_in(1, 5'd9, 32'h0BADF00D, 1, 5'd9, 0, 0, 0);
        tick();
        n_checks++;
        if (PENDING[9] !== 1'b1) $display("FAIL wr_iss_pending got %b exp 1", PENDING[9]);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 5'd9, 5'd0);
            n_checks++;
            if (REQ_READY !== 1'b0) $display("FAIL wr_iss_stall%0d got %b exp 0", c, REQ_READY);
            else n_pass++;
            tick();
        end
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 1, 5'd9, 5'd0);
        tick();
        n_checks++;
        if (PENDING !== 32'd0 || RSP_VALID !== 1'b0)
            $display("FAIL mid_reset got pend=%h v=%b exp 0 0", PENDING, RSP_VALID);
        else n_pass++;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 1, 5'd9, 5'd9);
        n_checks++;
        if (REQ_READY !== 1'b1) $display("FAIL after_reset_ready got %b exp 1", REQ_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP_VALID !== 1'b1 || RS1_DATA !== 32'd0)
            $display("FAIL after_reset_x9 got v=%b %h exp v=1 0", RSP_VALID, RS1_DATA);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            set_in($urandom_range(0, 1),
                   5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 99) < 15),
                   5'($urandom_range(0, 7)),
                   $urandom_range(0, 1),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            n_checks++;
            if (REQ_READY !== m_ready())
                $display("FAIL rnd_ready c=%0d got %b exp %b", c, REQ_READY, m_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (RSP_VALID !== m_rv)
                $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, RSP_VALID, m_rv);
            else n_pass++;
            n_checks++;
            if (RS1_DATA !== m_d1 || RS2_DATA !== m_d2)
                $display("FAIL rnd_data c=%0d got %h %h exp %h %h", c, RS1_DATA, RS2_DATA, m_d1, m_d2);
            else n_pass++;
            n_checks++;
            if (PENDING !== m_pend)
                $display("FAIL rnd_pending c=%0d got %h exp %h", c, PENDING, m_pend);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = '0;
        m_rv = 1'b0;
        m_d1 = 32'd0;
        m_d2 = 32'd0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_x0();
        test_back_to_back();
        test_write_issue_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
